// File: rtl/golomb_coder_if.sv
// Stream bundle between error_calc, the Golomb-Rice coder and the packed-word sink.
// The coder is the slave; the producer/consumer side uses master.
interface golomb_coder_if #(
   parameter int MERR_WIDTH = 19,
   parameter int ACC_LOG    = 5,
   parameter int OUT_WIDTH  = 32
);
   logic                  merr_valid;
   logic                  merr_ready;
   logic [MERR_WIDTH-1:0] merr_data;
   logic                  kj_valid;
   logic                  kj_ready;
   logic [ACC_LOG-1:0]    kj_data;
   logic                  out_valid;
   logic                  out_ready;
   logic [OUT_WIDTH-1:0]  out_data;
   logic                  out_last;

   modport master (
      output merr_valid, merr_data, kj_valid, kj_data, out_ready,
      input  merr_ready, kj_ready, out_valid, out_data, out_last
   );

   modport slave (
      input  merr_valid, merr_data, kj_valid, kj_data, out_ready,
      output merr_ready, kj_ready, out_valid, out_data, out_last
   );
endinterface

// File: rtl/golomb_coder.sv
// Golomb-Rice coder: joins merr/kj, builds one codeword per sample and packs the
// bit stream MSB-first into OUT_WIDTH words, zero-padding and flagging each block end.
module golomb_coder #(
   parameter int BANDS          = 224,
   parameter int DATA_WIDTH     = 16,
   parameter int BLOCK_SIZE_LOG = 8,
   parameter int ACC_LOG        = 5,
   parameter int U_MAX          = 16,
   parameter int OUT_WIDTH      = 32,
   parameter int MERR_WIDTH     = DATA_WIDTH + 3
) (
   input  logic          clk,
   input  logic          rst,
   golomb_coder_if.slave bus
);
   localparam int MAX_LEN = U_MAX + MERR_WIDTH;
   localparam int LEN_W   = $clog2(MAX_LEN + 1);
   localparam int BUF_W   = OUT_WIDTH - 1 + MAX_LEN;
   localparam int CNT_W   = $clog2(BUF_W + 1);
   localparam int SPB     = BANDS * (2 ** BLOCK_SIZE_LOG);
   localparam int SMP_W   = $clog2(SPB + 1);

   localparam logic [1:0] ACCEPT = 2'd0;
   localparam logic [1:0] EMIT1  = 2'd1;
   localparam logic [1:0] EMIT2  = 2'd2;
   localparam logic [1:0] FLUSH  = 2'd3;

   typedef struct packed {
      logic [LEN_W-1:0]   len;
      logic [MAX_LEN-1:0] cw;
   } code_t;

   function automatic logic [LEN_W-1:0] sat_k(input logic [ACC_LOG-1:0] kj);
      if (32'(kj) > 32'(MERR_WIDTH)) return LEN_W'(MERR_WIDTH);
      return LEN_W'(kj);
   endfunction

   function automatic code_t gr_code(input logic [MERR_WIDTH-1:0] merr,
                                     input logic [ACC_LOG-1:0]    kj);
      code_t                 c;
      logic [LEN_W-1:0]      k;
      logic [MERR_WIDTH-1:0] q;
      logic [MERR_WIDTH-1:0] r;
      k = sat_k(kj);
      q = merr >> k;
      r = merr & ~({MERR_WIDTH{1'b1}} << k);
      if (q < MERR_WIDTH'(U_MAX)) begin
         c.cw  = (((MAX_LEN'(1) << q) - MAX_LEN'(1)) << (k + LEN_W'(1))) | MAX_LEN'(r);
         c.len = LEN_W'(q) + k + LEN_W'(1);
      end else begin
         c.cw  = {{U_MAX{1'b1}}, merr};
         c.len = LEN_W'(MAX_LEN);
      end
      return c;
   endfunction

   // Valid bits sit right-aligned; anything above bit n-1 is stale and falls off here.
   function automatic logic [OUT_WIDTH-1:0] word_at(input logic [BUF_W-1:0] b,
                                                    input logic [CNT_W-1:0] n);
      return OUT_WIDTH'(b >> (n - CNT_W'(OUT_WIDTH)));
   endfunction

   function automatic logic [OUT_WIDTH-1:0] pad_word(input logic [BUF_W-1:0] b,
                                                     input logic [CNT_W-1:0] n);
      return OUT_WIDTH'(b << (CNT_W'(OUT_WIDTH) - n));
   endfunction

   logic                  vld_p1;
   logic [MAX_LEN-1:0]    cw_p1;
   logic [LEN_W-1:0]      len_p1;
   logic                  last_p1;
   logic [SMP_W-1:0]      smp_cnt;
   logic [1:0]            state;
   logic [BUF_W-1:0]      bits_p2;
   logic [CNT_W-1:0]      cnt_p2;
   logic                  blk_end_p2;
   logic                  out_valid_p2;
   logic [OUT_WIDTH-1:0]  out_data_p2;
   logic                  out_last_p2;
   code_t                 code_p0;
   logic                  take;
   logic                  join_ok;
   logic                  last_smp;
   logic [BUF_W-1:0]      bits_cat;
   logic [CNT_W-1:0]      cnt_cat;

   assign code_p0  = gr_code(bus.merr_data, bus.kj_data);
   assign take     = vld_p1 && (state == ACCEPT);
   assign join_ok  = rst && bus.merr_valid && bus.kj_valid && (!vld_p1 || take);
   assign last_smp = (smp_cnt == SMP_W'(SPB - 1));
   assign bits_cat = (bits_p2 << len_p1) | BUF_W'(cw_p1);
   assign cnt_cat  = cnt_p2 + CNT_W'(len_p1);

   assign bus.merr_ready = join_ok;
   assign bus.kj_ready   = join_ok;
   assign bus.out_valid  = out_valid_p2;
   assign bus.out_data   = out_data_p2;
   assign bus.out_last   = out_last_p2;

   // Stage 1: joined sample -> codeword
   always_ff @(posedge clk) begin
      if (!rst) begin
         vld_p1  <= 1'b0;
         smp_cnt <= '0;
      end else begin
         if (take) vld_p1 <= 1'b0;
         if (join_ok) begin
            vld_p1  <= 1'b1;
            smp_cnt <= last_smp ? '0 : smp_cnt + SMP_W'(1);
         end
      end
   end

   always_ff @(posedge clk) begin
      if (join_ok) begin
         cw_p1   <= code_p0.cw;
         len_p1  <= code_p0.len;
         last_p1 <= last_smp;
      end
   end

   // Stage 2: bit packer and output handshake
   always_ff @(posedge clk) begin
      if (!rst) begin
         state        <= ACCEPT;
         bits_p2      <= '0;
         cnt_p2       <= '0;
         blk_end_p2   <= 1'b0;
         out_valid_p2 <= 1'b0;
         out_data_p2  <= '0;
         out_last_p2  <= 1'b0;
      end else begin
         case (state)
            ACCEPT: if (vld_p1) begin
               bits_p2    <= bits_cat;
               blk_end_p2 <= last_p1;
               if (cnt_cat >= CNT_W'(OUT_WIDTH)) begin
                  cnt_p2       <= cnt_cat - CNT_W'(OUT_WIDTH);
                  out_valid_p2 <= 1'b1;
                  out_data_p2  <= word_at(bits_cat, cnt_cat);
                  out_last_p2  <= last_p1 && (cnt_cat == CNT_W'(OUT_WIDTH));
                  state        <= EMIT1;
               end else if (last_p1) begin
                  cnt_p2       <= cnt_cat;
                  out_valid_p2 <= 1'b1;
                  out_data_p2  <= pad_word(bits_cat, cnt_cat);
                  out_last_p2  <= 1'b1;
                  state        <= FLUSH;
               end else begin
                  cnt_p2 <= cnt_cat;
               end
            end
            EMIT1: if (bus.out_ready) begin
               if (cnt_p2 >= CNT_W'(OUT_WIDTH)) begin
                  cnt_p2      <= cnt_p2 - CNT_W'(OUT_WIDTH);
                  out_data_p2 <= word_at(bits_p2, cnt_p2);
                  out_last_p2 <= blk_end_p2 && (cnt_p2 == CNT_W'(OUT_WIDTH));
                  state       <= EMIT2;
               end else if (blk_end_p2 && (cnt_p2 != '0)) begin
                  out_data_p2 <= pad_word(bits_p2, cnt_p2);
                  out_last_p2 <= 1'b1;
                  state       <= FLUSH;
               end else begin
                  out_valid_p2 <= 1'b0;
                  out_last_p2  <= 1'b0;
                  state        <= ACCEPT;
               end
            end
            EMIT2: if (bus.out_ready) begin
               if (blk_end_p2 && (cnt_p2 != '0)) begin
                  out_data_p2 <= pad_word(bits_p2, cnt_p2);
                  out_last_p2 <= 1'b1;
                  state       <= FLUSH;
               end else begin
                  out_valid_p2 <= 1'b0;
                  out_last_p2  <= 1'b0;
                  state        <= ACCEPT;
               end
            end
            default: if (bus.out_ready) begin
               cnt_p2       <= '0;
               out_valid_p2 <= 1'b0;
               out_last_p2  <= 1'b0;
               state        <= ACCEPT;
            end
         endcase
      end
   end
endmodule

// File: tb/tb_golomb_coder.sv
// Scoreboard bench for golomb_coder: a bit-queue Golomb-Rice model predicts every packed
// word at the moment a sample is accepted; a negedge monitor pops and compares.
module tb_golomb_coder;
   localparam int MW = 19;
   localparam int AL = 5;
   localparam int OW = 32;

   logic clk;
   logic rst;

   golomb_coder_if #(.MERR_WIDTH(MW), .ACC_LOG(AL), .OUT_WIDTH(OW)) bus ();

   golomb_coder #(.BANDS(1), .BLOCK_SIZE_LOG(3)) dut (
      .clk(clk),
      .rst(rst),
      .bus(bus)
   );

   int          n_checks = 0;
   int          n_errors = 0;
   logic [31:0] exp_data_q[$];
   logic        exp_last_q[$];
   bit          mbits[$];
   int          msmp = 0;
   int          words_seen = 0;
   logic [31:0] last_word = '0;
   logic        last_flag = 1'b0;
   logic        stall_prev = 1'b0;
   logic [31:0] stall_data = '0;
   logic        stall_last = 1'b0;
   logic        rand_rdy = 1'b0;

   initial begin
      clk = 1'b0;
      forever #5 clk = ~clk;
   end

   initial begin
      #500000;
      $display("FAIL global_timeout");
      $fatal(1, "simulation time limit");
   end

   task automatic check_eq(input string tag, input logic [63:0] got, input logic [63:0] exp);
      n_checks++;
      if (got !== exp) begin
         n_errors++;
         $display("FAIL %s got=%0h exp=%0h", tag, got, exp);
      end
   endtask

   task automatic model_push(input logic [MW-1:0] m, input logic [AL-1:0] kj);
      int          k;
      int          q;
      logic [31:0] w;
      k = (int'(kj) > MW) ? MW : int'(kj);
      q = int'(m >> k);
      if (q < 16) begin
         repeat (q) mbits.push_back(1'b1);
         mbits.push_back(1'b0);
         for (int i = k - 1; i >= 0; i--) mbits.push_back(m[i]);
      end else begin
         repeat (16) mbits.push_back(1'b1);
         for (int i = MW - 1; i >= 0; i--) mbits.push_back(m[i]);
      end
      while (mbits.size() >= 32) begin
         for (int i = 31; i >= 0; i--) w[i] = mbits.pop_front();
         exp_data_q.push_back(w);
         exp_last_q.push_back(1'b0);
      end
      msmp++;
      if (msmp == 8) begin
         msmp = 0;
         if (mbits.size() > 0) begin
            w = '0;
            for (int i = 31; i >= 0 && mbits.size() > 0; i--) w[i] = mbits.pop_front();
            exp_data_q.push_back(w);
            exp_last_q.push_back(1'b1);
         end else if (exp_last_q.size() > 0) begin
            exp_last_q[exp_last_q.size() - 1] = 1'b1;
         end
      end
   endtask

   // Monitor: values seen at negedge are what the next rising edge transfers.
   initial begin
      forever begin
         @(negedge clk);
         if (rst && bus.merr_valid && bus.kj_valid && bus.merr_ready)
            model_push(bus.merr_data, bus.kj_data);
         check_eq("ready_pair", 64'(bus.kj_ready), 64'(bus.merr_ready));
         if (stall_prev && bus.out_valid) begin
            check_eq("stall_data", 64'(bus.out_data), 64'(stall_data));
            check_eq("stall_last", 64'(bus.out_last), 64'(stall_last));
         end
         stall_prev = 1'b0;
         if (bus.out_valid && bus.out_ready) begin
            if (exp_data_q.size() == 0) begin
               check_eq("extra_word_qlen", 64'(exp_data_q.size()), 64'd1);
            end else begin
               check_eq("word", 64'(bus.out_data), 64'(exp_data_q.pop_front()));
               check_eq("last", 64'(bus.out_last), 64'(exp_last_q.pop_front()));
            end
            words_seen++;
            last_word = bus.out_data;
            last_flag = bus.out_last;
         end else if (bus.out_valid) begin
            stall_prev = 1'b1;
            stall_data = bus.out_data;
            stall_last = bus.out_last;
         end
      end
   end

   initial begin
      forever begin
         @(posedge clk);
         #1;
         bus.out_ready = rand_rdy ? 1'($urandom_range(0, 1)) : 1'b1;
      end
   end

   task automatic send(input logic [MW-1:0] m, input logic [AL-1:0] k);
      int n;
      n = 0;
      bus.merr_valid = 1'b1;
      bus.kj_valid   = 1'b1;
      bus.merr_data  = m;
      bus.kj_data    = k;
      forever begin
         @(negedge clk);
         if (bus.merr_ready) break;
         n++;
         if (n > 1000) begin
            check_eq("send_timeout", 64'(bus.merr_ready), 64'd1);
            break;
         end
      end
      @(posedge clk);
      #1;
      bus.merr_valid = 1'b0;
      bus.kj_valid   = 1'b0;
   endtask

   task automatic wait_drain();
      int n;
      n = 0;
      while ((exp_data_q.size() != 0 || bus.out_valid) && n < 5000) begin
         @(negedge clk);
         n++;
      end
      check_eq("drain_qlen", 64'(exp_data_q.size()), 64'd0);
      @(posedge clk);
      #1;
   endtask

   initial begin
      rst            = 1'b0;
      bus.merr_valid = 1'b1;
      bus.kj_valid   = 1'b1;
      bus.merr_data  = 19'd5;
      bus.kj_data    = 5'd1;
      bus.out_ready  = 1'b1;
      repeat (3) @(posedge clk);
      @(negedge clk);
      check_eq("rst_out_valid", 64'(bus.out_valid), 64'd0);
      check_eq("rst_out_data", 64'(bus.out_data), 64'd0);
      check_eq("rst_out_last", 64'(bus.out_last), 64'd0);
      check_eq("rst_merr_ready", 64'(bus.merr_ready), 64'd0);
      check_eq("rst_kj_ready", 64'(bus.kj_ready), 64'd0);
      @(posedge clk);
      #1;
      rst            = 1'b1;
      bus.merr_valid = 1'b0;
      bus.kj_valid   = 1'b0;

      // exactly 32 bits per block: no flush word
      words_seen = 0;
      repeat (8) send(19'd5, 5'd1);
      wait_drain();
      check_eq("c1_words", 64'(words_seen), 64'd1);
      check_eq("c1_data", 64'(last_word), 64'hDDDDDDDD);
      check_eq("c1_last", 64'(last_flag), 64'd1);

      // 8 pending bits flushed as one padded word
      words_seen = 0;
      repeat (8) send(19'd0, 5'd0);
      wait_drain();
      check_eq("c2_words", 64'(words_seen), 64'd1);
      check_eq("c2_data", 64'(last_word), 64'h0);
      check_eq("c2_last", 64'(last_flag), 64'd1);

      // escape codeword followed by short ones: 42 bits -> full word + flush
      words_seen = 0;
      send(19'd40, 5'd0);
      repeat (7) send(19'd0, 5'd0);
      wait_drain();
      check_eq("c3_words", 64'(words_seen), 64'd2);
      check_eq("c3_last", 64'(last_flag), 64'd1);

      // merr presented alone must not be consumed
      words_seen     = 0;
      bus.merr_valid = 1'b1;
      bus.merr_data  = 19'd5;
      bus.kj_valid   = 1'b0;
      bus.kj_data    = 5'd1;
      repeat (5) begin
         @(negedge clk);
         check_eq("stag_merr_ready", 64'(bus.merr_ready), 64'd0);
         check_eq("stag_kj_ready", 64'(bus.kj_ready), 64'd0);
         @(posedge clk);
         #1;
      end
      repeat (8) send(19'd5, 5'd1);
      wait_drain();
      check_eq("stag_words", 64'(words_seen), 64'd1);
      check_eq("stag_data", 64'(last_word), 64'hDDDDDDDD);
      check_eq("stag_last", 64'(last_flag), 64'd1);

      // random samples under random back-pressure
      rand_rdy = 1'b1;
      for (int i = 0; i < 1000; i++) begin
         logic [AL-1:0] k;
         logic [MW-1:0] m;
         k = AL'($urandom_range(0, 31));
         m = MW'($urandom) >> $urandom_range(0, 18);
         send(m, k);
      end
      wait_drain();
      rand_rdy = 1'b0;

      // reset mid-block discards the partial block
      words_seen = 0;
      repeat (3) send(19'd5, 5'd1);
      bus.merr_valid = 1'b1;
      bus.kj_valid   = 1'b1;
      bus.merr_data  = 19'd5;
      bus.kj_data    = 5'd1;
      rst            = 1'b0;
      mbits.delete();
      exp_data_q.delete();
      exp_last_q.delete();
      msmp = 0;
      @(posedge clk);
      @(negedge clk);
      check_eq("mrst_out_valid", 64'(bus.out_valid), 64'd0);
      check_eq("mrst_out_data", 64'(bus.out_data), 64'd0);
      check_eq("mrst_out_last", 64'(bus.out_last), 64'd0);
      check_eq("mrst_merr_ready", 64'(bus.merr_ready), 64'd0);
      @(posedge clk);
      #1;
      rst            = 1'b1;
      bus.merr_valid = 1'b0;
      bus.kj_valid   = 1'b0;
      repeat (8) send(19'd5, 5'd1);
      wait_drain();
      check_eq("mrst_words", 64'(words_seen), 64'd1);
      check_eq("mrst_data", 64'(last_word), 64'hDDDDDDDD);
      check_eq("mrst_last", 64'(last_flag), 64'd1);

      $display("CHECKS %0d ERRORS %0d", n_checks, n_errors);
      $finish;
   end
endmodule
